// File: rtl/alu_exec_unit_pkg.sv
// Shared defaults, ALU op codes and FSM encodings for the execute-stage ALU.
package alu_exec_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned SHAMT_WIDTH_DEF = 5;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_DEF = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative 1-bit-per-step shifter: working register plus down-counter.
module alu_iter_shifter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   step,
  input  logic                   dir,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  next_c,
  output logic                   done_c
);

  logic [DATA_WIDTH-1:0]  work;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   dir_q;

  // dir_q=1 selects a logical right shift, otherwise left; zero fill both ways
  always_comb begin
    next_c = dir_q ? (work >> 1) : (work << 1);
    done_c = (cnt == SHAMT_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      work  <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (load) begin
      work  <= din;
      cnt   <= shamt;
      dir_q <= dir;
    end else if (step && (cnt != '0)) begin
      work  <= next_c;
      cnt   <= cnt - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add ops, iterative shifts, valid/ready on both sides.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   Illegal
);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] result_next;
  logic [DATA_WIDTH-1:0] op_result;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  zero_next;
  logic                  illegal_next;
  logic                  op_illegal;
  logic                  is_shift;
  logic                  sh_load;
  logic                  sh_step;
  logic                  sh_dir;
  logic                  sh_done;

  // Single-cycle datapath; shifts report B so a zero shift amount finishes here
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    is_shift   = 1'b0;
    sh_dir     = (ALUOperation == OP_SRL);
    case (ALUOperation)
      OP_AND:         op_result = A & B;
      OP_OR:          op_result = A | B;
      OP_NOR:         op_result = ~(A | B);
      OP_ADD:         op_result = A + B;
      OP_SLL, OP_SRL: begin
        is_shift  = 1'b1;
        op_result = B;
      end
      default:        op_illegal = 1'b1;
    endcase
  end

  alu_iter_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (sh_load),
    .step   (sh_step),
    .dir    (sh_dir),
    .shamt  (shamt),
    .din    (B),
    .next_c (sh_next),
    .done_c (sh_done)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_next   = state;
    result_next  = ALUResult;
    illegal_next = Illegal;
    zero_next    = Zero;
    sh_load      = 1'b0;
    sh_step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            sh_load    = 1'b1;
            state_next = ST_SHIFT;
          end else begin
            result_next  = op_result;
            illegal_next = op_illegal;
            state_next   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        sh_step = 1'b1;
        if (sh_done) begin
          result_next  = sh_next;
          illegal_next = 1'b0;
          state_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    zero_next = (result_next == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Illegal   <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == ST_IDLE);
      out_valid <= (state_next == ST_DONE);
      ALUResult <= result_next;
      Zero      <= zero_next;
      Illegal   <= illegal_next;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute stage that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with the operands, and produces a registered result. AND/OR/NOR/ADD complete in one cycle. SLL/SRL use an iterative 1-bit-per-cycle shifter to save area. A valid/ready handshake on both sides lets the multicycle datapath stall on long shifts.

Parameters:
DATA_WIDTH, 32, operand/result width
SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  operation request present
in_ready  output  1  unit can accept a request this cycle
ALUOperation  input  4  operation code from ALU control
A  input  DATA_WIDTH  operand A (rs)
B  input  DATA_WIDTH  operand B (rt or immediate); shift source
shamt  input  SHAMT_WIDTH  shift amount for SLL/SRL
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
ALUResult  output  DATA_WIDTH  registered result
Zero  output  1  ALUResult == 0
Illegal  output  1  op code not supported; result forced to 0

Behaviour:
- Op codes: 0000 AND; 0001 OR; 0010 NOR; 0011 ADD; 0101 SLL; 0110 SRL. Every other code, including 1001, sets Illegal=1 and ALUResult=0.
- ADD wraps modulo 2^DATA_WIDTH. There is no overflow flag.
- SLL/SRL shift B by shamt with zero fill. A is ignored for shifts.
- FSM states:
  - IDLE: in_ready=1. Accept when in_valid=1. Operands, op and shamt are captured. Then:
    - Non-shift or illegal op: result computed, go to DONE.
    - Shift with shamt=0: ALUResult=B, go to DONE.
    - Shift with shamt>0: working register=B, counter=shamt, go to SHIFT.
  - SHIFT: shift the working register one bit per cycle and decrement the counter. On the cycle the counter reaches 0 the final value is loaded into ALUResult and the FSM goes to DONE. The unit spends exactly shamt cycles in SHIFT.
  - DONE: out_valid=1. ALUResult, Zero and Illegal stay stable until out_ready=1, then the FSM goes to IDLE.
- Latency (accept edge to out_valid high):
  - 1 cycle for non-shift ops and shamt=0.
  - shamt+1 cycles for shifts.
  - Maximum 32 cycles at default parameters.
- Throughput: at most one operation per 2 cycles. in_ready is low in SHIFT and DONE, so no request is accepted while one is outstanding.
- Inputs are sampled only on the accept edge. Changes to A, B, op or shamt afterwards have no effect on the result.
- Zero and Illegal are registered together with ALUResult and are meaningful only while out_valid=1.
- Reset (reset=0 at a rising edge) wins over everything, including mid-shift and during DONE:
  - FSM goes to IDLE; an in-flight operation is discarded.
  - Reset values: in_ready=1, out_valid=0, ALUResult=0, Zero=1, Illegal=0; counter and working register cleared.
  - in_ready=1 on the first cycle after reset.
- out_ready while not in DONE is ignored.
- in_valid while in_ready=0 is ignored. The requester must hold the request until it sees in_ready=1.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and SHAMT_WIDTH defaults.
  - ALU op-code constants (AND, OR, NOR, ADD, SLL, SRL, and the default 1001).
  - FSM state encodings IDLE/SHIFT/DONE.
- One sub-module is natural: alu_iter_shifter. It holds the working register and down-counter, takes load/dir/shamt inputs, and has a done output. The top level keeps the FSM, handshake and combinational logic ops.

Test Plan:
- ADD, A=0xFFFFFFFF, B=0x00000001, in_valid=1, out_ready=1 → out_valid one cycle after accept; ALUResult=0x00000000, Zero=1, Illegal=0 (wrap).
- NOR, A=0x0F0F0F0F, B=0x00FF00FF → ALUResult=0xF000F000, Zero=0, latency 1.
- SLL, B=0x00000003, shamt=4 → in_ready=0 for the 5 cycles after the accept edge; out_valid on cycle 5; ALUResult=0x00000030. Repeat SRL with B=0x80000000, shamt=31 → 0x00000001 after 32 cycles.
- SLL with shamt=0, B=0x12345678 → ALUResult=0x12345678, latency 1. Op 1001 with any operands → Illegal=1, ALUResult=0, Zero=1.
- Backpressure: complete an OR, hold out_ready=0 for 3 cycles while changing A/B → result stable, in_ready=0. Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-shift: start SRL with shamt=20, assert reset=0 at cycle 5 → next cycle out_valid=0, in_ready=1, ALUResult=0. A new ADD 2+3 then yields 5 with no residue from the aborted shift.
